// File: rtl/cost_epoch_ctrl_if.sv
// Handshake/data bundle between the training sequencer side (master) and cost_epoch_ctrl (slave).
interface cost_epoch_ctrl_if #(
    parameter int WIDTH   = 32,
    parameter int EPOCH_W = 16
);
    logic               i_start;
    logic               i_sample_done;
    logic [WIDTH-1:0]   i_cost;
    logic [WIDTH-1:0]   i_thresh;
    logic               o_acc_clr;
    logic               o_hold;
    logic [WIDTH-1:0]   o_cost;
    logic [WIDTH-1:0]   o_best;
    logic               o_valid;
    logic [EPOCH_W-1:0] o_epoch;
    logic               o_done;
    logic               o_conv;

    modport master (
        output i_start, i_sample_done, i_cost, i_thresh,
        input  o_acc_clr, o_hold, o_cost, o_best, o_valid, o_epoch, o_done, o_conv
    );

    modport slave (
        input  i_start, i_sample_done, i_cost, i_thresh,
        output o_acc_clr, o_hold, o_cost, o_best, o_valid, o_epoch, o_done, o_conv
    );
endinterface

// File: rtl/cost_epoch_ctrl.sv
// Epoch monitor: last sample at t -> LATCH t+1 -> o_valid/o_acc_clr t+2 -> o_done t+3; o_hold drops samples in LATCH/CHECK.
// `COST_EPOCH_AVG_EN latches the per-sample mean (N_SAMPLE must then be a power of two).
module cost_epoch_ctrl #(
    parameter int WIDTH     = 32,
    parameter int FRAC      = 24,
    parameter int N_SAMPLE  = 4,
    parameter int MAX_EPOCH = 1000,
    parameter int PATIENCE  = 8,
    parameter int EPOCH_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    cost_epoch_ctrl_if.slave bus
);
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] RUN   = 3'd1;
    localparam logic [2:0] LATCH = 3'd2;
    localparam logic [2:0] CHECK = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;

    localparam int CNT_W   = (N_SAMPLE > 1) ? $clog2(N_SAMPLE) : 1;
    localparam int STALL_W = $clog2(PATIENCE + 1);

    localparam logic [WIDTH-1:0]   MAX_POS   = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [CNT_W-1:0]   SMP_LAST  = CNT_W'(N_SAMPLE - 1);
    localparam logic [STALL_W-1:0] PAT_V     = STALL_W'(PATIENCE);
    localparam logic [EPOCH_W:0]   MAX_EP_V  = (EPOCH_W+1)'(MAX_EPOCH);

    if (FRAC >= WIDTH) begin : g_bad_frac
        $error("cost_epoch_ctrl: FRAC must be smaller than WIDTH");
    end

    logic [WIDTH-1:0] latch_val;

`ifdef COST_EPOCH_AVG_EN
    localparam int SHIFT = $clog2(N_SAMPLE);

    if ((1 << SHIFT) != N_SAMPLE) begin : g_bad_nsample
        $error("cost_epoch_ctrl: N_SAMPLE must be a power of two when averaging");
    end

    assign latch_val = $signed(bus.i_cost) >>> SHIFT;
`else
    assign latch_val = bus.i_cost;
`endif

    logic [2:0]         state;
    logic [CNT_W-1:0]   smp_cnt;
    logic [STALL_W-1:0] stall_cnt;
    logic [WIDTH-1:0]   cost_q;
    logic [WIDTH-1:0]   best_q;
    logic [EPOCH_W-1:0] epoch_q;
    logic               valid_q;
    logic               acc_clr_q;
    logic               hold_q;
    logic               done_q;
    logic               conv_q;

    // Improvement must be strict: an equal cost counts toward patience.
    logic               improved;
    logic [STALL_W-1:0] stall_nxt;
    logic               hit_thresh;

    assign improved   = $signed(cost_q) < $signed(best_q);
    assign stall_nxt  = improved ? '0 : stall_cnt + 1'b1;
    assign hit_thresh = $signed(cost_q) <= $signed(bus.i_thresh);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            smp_cnt   <= '0;
            stall_cnt <= '0;
            cost_q    <= '0;
            best_q    <= MAX_POS;
            epoch_q   <= '0;
            valid_q   <= 1'b0;
            acc_clr_q <= 1'b0;
            hold_q    <= 1'b0;
            done_q    <= 1'b0;
            conv_q    <= 1'b0;
        end else begin
            valid_q   <= 1'b0;
            acc_clr_q <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (bus.i_start) begin
                        state     <= RUN;
                        acc_clr_q <= 1'b1;
                        smp_cnt   <= '0;
                        stall_cnt <= '0;
                        epoch_q   <= '0;
                        best_q    <= MAX_POS;
                        done_q    <= 1'b0;
                        conv_q    <= 1'b0;
                    end
                end
                RUN: begin
                    if (bus.i_sample_done) begin
                        if (smp_cnt == SMP_LAST) begin
                            smp_cnt <= '0;
                            state   <= LATCH;
                            hold_q  <= 1'b1;
                        end else begin
                            smp_cnt <= smp_cnt + 1'b1;
                        end
                    end
                end
                LATCH: begin
                    cost_q    <= latch_val;
                    valid_q   <= 1'b1;
                    acc_clr_q <= 1'b1;
                    if (epoch_q != '1) begin
                        epoch_q <= epoch_q + 1'b1;
                    end
                    state     <= CHECK;
                end
                CHECK: begin
                    hold_q    <= 1'b0;
                    stall_cnt <= stall_nxt;
                    if (improved) begin
                        best_q <= cost_q;
                    end
                    if (hit_thresh) begin
                        state  <= DONE;
                        done_q <= 1'b1;
                        conv_q <= 1'b1;
                    end else if (stall_nxt >= PAT_V || {1'b0, epoch_q} >= MAX_EP_V) begin
                        state  <= DONE;
                        done_q <= 1'b1;
                    end else begin
                        state  <= RUN;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.o_cost    = cost_q;
    assign bus.o_best    = best_q;
    assign bus.o_epoch   = epoch_q;
    assign bus.o_valid   = valid_q;
    assign bus.o_acc_clr = acc_clr_q;
    assign bus.o_hold    = hold_q;
    assign bus.o_done    = done_q;
    assign bus.o_conv    = conv_q;
endmodule

// File: tb/tb_cost_epoch_ctrl.sv
// Randomized bench for cost_epoch_ctrl against an epoch-level reference model.
module tb_cost_epoch_ctrl;
    localparam int N    = 4;
    localparam int MAXE = 12;
    localparam int PAT  = 8;
    localparam logic [31:0] MAXPOS = 32'h7FFF_FFFF;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cost_epoch_ctrl_if #(.WIDTH(32), .EPOCH_W(16)) bus ();

    cost_epoch_ctrl #(
        .WIDTH(32), .FRAC(24), .N_SAMPLE(N), .MAX_EPOCH(MAXE), .PATIENCE(PAT), .EPOCH_W(16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state for the current run
    int m_best, m_stall, m_epoch, m_thr;
    bit m_done, m_conv;
    int cost_tab [16];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Value the block should store for an epoch sum: the sum itself, or its floor mean.
    function automatic int stored(input int sum);
`ifdef COST_EPOCH_AVG_EN
        int q;
        q = sum / N;
        if ((sum % N) != 0 && sum < 0) q = q - 1;
        return q;
`else
        return sum;
`endif
    endfunction

    task automatic check_reset(input string pfx);
        chk({pfx, "_cost"},    bus.o_cost, 32'h0);
        chk({pfx, "_best"},    bus.o_best, MAXPOS);
        chk({pfx, "_epoch"},   32'(bus.o_epoch), 32'h0);
        chk({pfx, "_valid"},   32'(bus.o_valid), 32'h0);
        chk({pfx, "_acc_clr"}, 32'(bus.o_acc_clr), 32'h0);
        chk({pfx, "_hold"},    32'(bus.o_hold), 32'h0);
        chk({pfx, "_done"},    32'(bus.o_done), 32'h0);
        chk({pfx, "_conv"},    32'(bus.o_conv), 32'h0);
    endtask

    task automatic do_epoch(input int cval, input bit poke);
        int st;
        bus.i_cost = cval;
        for (int k = 0; k < N; k++) begin
            int gap;
            gap = int'($urandom_range(0, 2));
            for (int g = 0; g < gap; g++) begin
                bus.i_start = ($urandom_range(0, 3) == 0);
                tick();
                bus.i_start = 1'b0;
            end
            chk("hold_run", 32'(bus.o_hold), 32'h0);
            bus.i_sample_done = 1'b1;
            tick();
            bus.i_sample_done = 1'b0;
        end
        // LATCH cycle
        chk("hold_latch", 32'(bus.o_hold), 32'h1);
        chk("valid_latch", 32'(bus.o_valid), 32'h0);
        bus.i_sample_done = poke;
        tick();

        st = stored(cval);
        m_epoch++;
        if (st < m_best) begin
            m_best  = st;
            m_stall = 0;
        end else begin
            m_stall++;
        end
        if (st <= m_thr) begin
            m_done = 1'b1;
            m_conv = 1'b1;
        end else if (m_stall >= PAT || m_epoch >= MAXE) begin
            m_done = 1'b1;
        end

        // CHECK cycle
        chk("valid_check", 32'(bus.o_valid), 32'h1);
        chk("clr_check", 32'(bus.o_acc_clr), 32'h1);
        chk("hold_check", 32'(bus.o_hold), 32'h1);
        chk("cost", bus.o_cost, st);
        chk("epoch", 32'(bus.o_epoch), m_epoch);
        bus.i_sample_done = poke;
        tick();
        bus.i_sample_done = 1'b0;

        chk("valid_after", 32'(bus.o_valid), 32'h0);
        chk("hold_after", 32'(bus.o_hold), 32'h0);
        chk("best", bus.o_best, m_best);
        chk("done", 32'(bus.o_done), 32'(m_done));
        chk("conv", 32'(bus.o_conv), 32'(m_conv));
    endtask

    task automatic run(input int thr);
        int e;
        m_thr   = thr;
        m_best  = int'(MAXPOS);
        m_stall = 0;
        m_epoch = 0;
        m_done  = 1'b0;
        m_conv  = 1'b0;
        bus.i_thresh = thr;
        bus.i_start  = 1'b1;
        tick();
        bus.i_start  = 1'b0;
        chk("start_clr", 32'(bus.o_acc_clr), 32'h1);
        chk("start_epoch", 32'(bus.o_epoch), 32'h0);
        chk("start_done", 32'(bus.o_done), 32'h0);
        chk("start_best", bus.o_best, MAXPOS);
        e = 0;
        while (!m_done && e < 16) begin
            do_epoch(cost_tab[e], 1'($urandom_range(0, 1)));
            e++;
        end
        bus.i_sample_done = 1'b1;
        tick();
        tick();
        bus.i_sample_done = 1'b0;
        chk("done_hold", 32'(bus.o_done), 32'h1);
        chk("conv_hold", 32'(bus.o_conv), 32'(m_conv));
        chk("epoch_hold", 32'(bus.o_epoch), m_epoch);
        chk("clr_idle", 32'(bus.o_acc_clr), 32'h0);
    endtask

    initial begin
        rst = 1'b1;
        bus.i_start = 1'b0;
        bus.i_sample_done = 1'b0;
        bus.i_cost = '0;
        bus.i_thresh = '0;
        tick();
        tick();
        check_reset("rst");
        rst = 1'b0;
        tick();

        // Converges on the first epoch
        cost_tab[0] = 32'h0080_0000;
        run(32'h0100_0000);

        // Patience stop: 5.0, 4.0, then eight equal 4.0 epochs
        cost_tab[0] = 32'h0500_0000;
        for (int i = 1; i < 10; i++) cost_tab[i] = 32'h0400_0000;
        run(0);

        // Epoch-limit stop with strictly decreasing costs
        for (int i = 0; i < MAXE; i++) cost_tab[i] = (MAXE - i) * 32'h0100_0000;
        run(0);

        // Negative cost, converges against zero threshold
        cost_tab[0] = 32'hFC00_0000;
        run(0);

        // Cost equal to threshold converges
        cost_tab[0] = 32'h0300_0000;
        cost_tab[1] = 32'h0200_0000;
        run(stored(32'h0200_0000));

        // Reset in the middle of RUN
        bus.i_thresh = '0;
        bus.i_cost = 32'h0100_0000;
        bus.i_start = 1'b1;
        tick();
        bus.i_start = 1'b0;
        for (int k = 0; k < 2; k++) begin
            bus.i_sample_done = 1'b1;
            tick();
            bus.i_sample_done = 1'b0;
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset("midrst");
        cost_tab[0] = 32'h0080_0000;
        run(32'h0100_0000);

        for (int r = 0; r < 25; r++) begin
            for (int i = 0; i < 16; i++) begin
                cost_tab[i] = (int'($urandom_range(0, 40)) - 10) * 32'h0040_0000;
            end
            run((int'($urandom_range(0, 14)) - 12) * 32'h0040_0000);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
